regfile_operand_sequencer: RTL and testbench
============================================

# regfile_operand_sequencer

Initiator side of the 16x16 register file's control bundle. Accepts decoded instructions (rs1, rs2, rd), drives the packed 13-bit register-file control word and write data, and captures both read operands into a one-deep output stage toward execute. Execute writebacks are committed through the same bundle. A 16-bit busy scoreboard stalls issue on read-after-write (RAW) and write-after-write (WAW) hazards, with same-cycle writeback bypass.

## Interface
No parameters; widths fixed: 16 registers, 16-bit data.
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- issue_valid  in  1  instruction offered
- issue_ready  out  1  instruction accepted when valid&ready at posedge
- issue_rs1  in  4  operand A register
- issue_rs2  in  4  operand B register
- issue_rd  in  4  destination register
- issue_rd_en  in  1  instruction will later write rd
- wb_valid  in  1  writeback this cycle; always accepted
- wb_addr  in  4  writeback register
- wb_data  in  16  writeback value
- rf_control  out  13  to register file: [0] write enable, [4:1] write address, [8:5] read address 1, [12:9] read address 2
- rf_write_data  out  16  to register file write data
- rf_read_data1  in  16  register file read port 1 (combinational)
- rf_read_data2  in  16  register file read port 2 (combinational)
- op_valid  out  1  operand stage holds an instruction
- op_ready  in  1  execute consumes when op_valid&op_ready
- op_a, op_b  out  16  captured operands
- op_rd  out  4  captured destination
- op_rd_en  out  1  captured write flag
- busy  out  16  scoreboard, bit i = write to register i pending

## Operation
- Control word, combinational: rf_control[0] = wb_valid & ~reset; [4:1] = wb_addr; [8:5] = issue_rs1; [12:9] = issue_rs2, driven unconditionally; rf_write_data = wb_data.
- Bypass: byp1 = wb_valid & (wb_addr == issue_rs1); srcA = byp1 ? wb_data : rf_read_data1; same for B with rs2.
- Hazard: haz = (busy[rs1] & ~byp1) | (busy[rs2] & ~byp2) | (issue_rd_en & busy[rd] & ~(wb_valid & wb_addr == rd)).
- issue_ready = ~reset & ~haz & (~op_valid | op_ready); may depend on issue fields, not on issue_valid.
- Accept: op_a←srcA, op_b←srcB, op_rd←issue_rd, op_rd_en←issue_rd_en, op_valid←1.
- Consume without accept: op_valid←0; op_a/op_b/op_rd/op_rd_en hold.
- Scoreboard per edge: clear busy[wb_addr] if wb_valid; then set busy[issue_rd] if accept & issue_rd_en. Set wins on same register (new writer pending).
- Writeback to a non-busy register is committed normally; busy is unchanged.
- Reset: busy=0, op_valid=0, op_a=op_b=0, op_rd=0, op_rd_en=0; rf_control[0]=0 and issue_ready=0 while reset is high. Reset mid-operation discards the held operand and all pending-write tracking.

## Timing
- Issue-to-operand latency 1: accepted at edge N → op_valid=1 from N+1.
- Throughput 1/cycle with op_ready held high and no hazards.
- Writeback commits to the register file at the same edge it is presented; bypass covers the read in that cycle.
- A RAW stall releases in the cycle wb_valid targets the busy register; the instruction issues that cycle with bypassed data.
- Full stage with op_ready=0 → issue_ready=0; simultaneous consume+accept keeps op_valid=1 and loads new data.

## Test plan
- Reset, then issue rs1=1, rs2=2, rd=3 (rd_en) with R1=0x0011, R2=0x0022 → op_a=0x0011, op_b=0x0022, op_rd=3 one cycle later; busy=0x0008.
- With busy[3] set, issue rs1=3 → issue_ready=0; wb_valid addr=3 data=0xBEEF → accepted same cycle, op_a=0xBEEF, busy[3] clears, register 3 = 0xBEEF.
- WAW: busy[5] set, issue rd=5 rd_en → stalled; wb addr=5 the same cycle → accepted, busy[5] remains 1.
- op_ready=0 with op_valid=1 → issue_ready=0, outputs held; raise op_ready with a new issue pending → back-to-back transfer, op_valid stays 1.
- Stream of 8 independent instructions, op_ready=1 → one accept per cycle, all operands correct.
- Assert reset with op_valid=1, busy=0xFFFF, wb_valid=1 → next cycle op_valid=0, busy=0, no register write.

Source files
------------

// File: rtl/regfile_operand_sequencer.sv
// Operand sequencer for a 16x16 register file: issues decoded instructions, reads
// both operands (with writeback bypass), tracks pending writes and stalls on RAW/WAW.
module regfile_operand_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [3:0]  issue_rs1,
  input  logic [3:0]  issue_rs2,
  input  logic [3:0]  issue_rd,
  input  logic        issue_rd_en,
  input  logic        wb_valid,
  input  logic [3:0]  wb_addr,
  input  logic [15:0] wb_data,
  output logic [12:0] rf_control,
  output logic [15:0] rf_write_data,
  input  logic [15:0] rf_read_data1,
  input  logic [15:0] rf_read_data2,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [15:0] op_a,
  output logic [15:0] op_b,
  output logic [3:0]  op_rd,
  output logic        op_rd_en,
  output logic [15:0] busy
);

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int NREG   = 16;

  function automatic logic [DATA_W-1:0] bypass_sel(input logic hit,
                                                   input logic [DATA_W-1:0] wb_val,
                                                   input logic [DATA_W-1:0] rf_val);
    return hit ? wb_val : rf_val;
  endfunction

  function automatic logic wb_hits(input logic vld, input logic [ADDR_W-1:0] wa,
                                   input logic [ADDR_W-1:0] ra);
    return vld && (wa == ra);
  endfunction

  logic              byp1_p0;
  logic              byp2_p0;
  logic              bypd_p0;
  logic              haz_p0;
  logic              accept_p0;
  logic              consume_p1;
  logic [DATA_W-1:0] src_a_p0;
  logic [DATA_W-1:0] src_b_p0;
  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   busy_nxt;

  logic              vld_p1;
  logic [DATA_W-1:0] a_p1;
  logic [DATA_W-1:0] b_p1;
  logic [ADDR_W-1:0] rd_p1;
  logic              rd_en_p1;

  // Stage p0: register-file addressing, bypass and hazard detection
  always_comb begin
    rf_control    = {issue_rs2, issue_rs1, wb_addr, wb_valid & ~reset};
    rf_write_data = wb_data;

    byp1_p0  = wb_hits(wb_valid, wb_addr, issue_rs1);
    byp2_p0  = wb_hits(wb_valid, wb_addr, issue_rs2);
    bypd_p0  = wb_hits(wb_valid, wb_addr, issue_rd);
    src_a_p0 = bypass_sel(byp1_p0, wb_data, rf_read_data1);
    src_b_p0 = bypass_sel(byp2_p0, wb_data, rf_read_data2);

    // A writeback landing this cycle releases the matching busy bit early.
    haz_p0 = (busy_q[issue_rs1] & ~byp1_p0) |
             (busy_q[issue_rs2] & ~byp2_p0) |
             (issue_rd_en & busy_q[issue_rd] & ~bypd_p0);

    issue_ready = ~reset & ~haz_p0 & (~vld_p1 | op_ready);
    accept_p0   = issue_valid & issue_ready;
    consume_p1  = vld_p1 & op_ready;
  end

  // Clear for the retiring write first so a new writer to the same register wins.
  always_comb begin
    busy_nxt = busy_q;
    if (wb_valid) begin
      busy_nxt[wb_addr] = 1'b0;
    end
    if (accept_p0 && issue_rd_en) begin
      busy_nxt[issue_rd] = 1'b1;
    end
  end

  // Stage p1: operand hold register toward execute
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1   <= 1'b0;
      a_p1     <= '0;
      b_p1     <= '0;
      rd_p1    <= '0;
      rd_en_p1 <= 1'b0;
      busy_q   <= '0;
    end else begin
      busy_q <= busy_nxt;
      if (accept_p0) begin
        vld_p1   <= 1'b1;
        a_p1     <= src_a_p0;
        b_p1     <= src_b_p0;
        rd_p1    <= issue_rd;
        rd_en_p1 <= issue_rd_en;
      end else if (consume_p1) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign op_valid = vld_p1;
  assign op_a     = a_p1;
  assign op_b     = b_p1;
  assign op_rd    = rd_p1;
  assign op_rd_en = rd_en_p1;
  assign busy     = busy_q;

endmodule

// File: tb/tb_regfile_operand_sequencer.sv
// Randomised and directed bench for regfile_operand_sequencer with a behavioural
// register file attached and an instruction-level reference model.
module tb_regfile_operand_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic        issue_ready;
  logic [3:0]  issue_rs1, issue_rs2, issue_rd;
  logic        issue_rd_en;
  logic        wb_valid;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic [12:0] rf_control;
  logic [15:0] rf_write_data;
  logic [15:0] rf_read_data1, rf_read_data2;
  logic        op_valid;
  logic        op_ready;
  logic [15:0] op_a, op_b;
  logic [3:0]  op_rd;
  logic        op_rd_en;
  logic [15:0] busy;

  regfile_operand_sequencer dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_rd(issue_rd),
    .issue_rd_en(issue_rd_en),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .rf_control(rf_control), .rf_write_data(rf_write_data),
    .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .op_rd(op_rd), .op_rd_en(op_rd_en),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Register file driven purely by the DUT's control bundle
  logic [15:0] rf_mem [16];
  always @(posedge clk) begin
    if (rf_control[0]) rf_mem[rf_control[4:1]] <= rf_write_data;
  end
  assign rf_read_data1 = rf_mem[rf_control[8:5]];
  assign rf_read_data2 = rf_mem[rf_control[12:9]];

  // Reference model: architectural registers, set of pending writers, operand slot
  logic [15:0] m_regs [16];
  logic        m_pend [16];
  logic        m_vld;
  logic [15:0] m_a, m_b;
  logic [3:0]  m_rd;
  logic        m_rden;
  int          n_acc;

  logic        samp_ready, exp_ready;
  logic [12:0] samp_ctl, exp_ctl;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [15:0] m_busy();
    logic [15:0] v;
    for (int i = 0; i < 16; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic logic model_ready();
    logic wait_a, wait_b, wait_d;
    wait_a = m_pend[issue_rs1] && !(wb_valid && wb_addr == issue_rs1);
    wait_b = m_pend[issue_rs2] && !(wb_valid && wb_addr == issue_rs2);
    wait_d = issue_rd_en && m_pend[issue_rd] && !(wb_valid && wb_addr == issue_rd);
    return !reset && !(wait_a || wait_b || wait_d) && (!m_vld || op_ready);
  endfunction

  task automatic model_step();
    logic acc;
    if (reset) begin
      for (int i = 0; i < 16; i++) m_pend[i] = 1'b0;
      m_vld = 0; m_a = 0; m_b = 0; m_rd = 0; m_rden = 0;
    end else begin
      acc = issue_valid && exp_ready;
      if (acc) begin
        m_a    = (wb_valid && wb_addr == issue_rs1) ? wb_data : m_regs[issue_rs1];
        m_b    = (wb_valid && wb_addr == issue_rs2) ? wb_data : m_regs[issue_rs2];
        m_rd   = issue_rd;
        m_rden = issue_rd_en;
        m_vld  = 1'b1;
        n_acc++;
      end else if (m_vld && op_ready) begin
        m_vld = 1'b0;
      end
      if (wb_valid) begin
        m_regs[wb_addr] = wb_data;
        m_pend[wb_addr] = 1'b0;
      end
      if (acc && issue_rd_en) m_pend[issue_rd] = 1'b1;
    end
  endtask

  // One clock: sample combinational outputs mid-cycle, advance model, land after the edge
  task automatic tick();
    @(negedge clk);
    samp_ready = issue_ready;
    samp_ctl   = rf_control;
    exp_ctl    = {issue_rs2, issue_rs1, wb_addr, wb_valid & ~reset};
    exp_ready  = model_ready();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_issue(input logic v, input logic [3:0] r1, input logic [3:0] r2,
                           input logic [3:0] rd, input logic en);
    issue_valid = v; issue_rs1 = r1; issue_rs2 = r2; issue_rd = rd; issue_rd_en = en;
  endtask

  task automatic set_wb(input logic v, input logic [3:0] a, input logic [15:0] d);
    wb_valid = v; wb_addr = a; wb_data = d;
  endtask

  task automatic test_reset();
    reset = 1'b1; op_ready = 1'b1;
    set_issue(1'b1, 4'd0, 4'd0, 4'd0, 1'b0);
    set_wb(1'b1, 4'd7, 16'h5555);
    tick();
    tick();
    checks++; if (samp_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", samp_ready); end
    checks++; if (samp_ctl[0] !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", samp_ctl[0]); end
    checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL reset_op_valid got %b exp 0", op_valid); end
    checks++; if (busy !== 16'h0000) begin errors++; $display("FAIL reset_busy got %h exp 0000", busy); end
    checks++; if ({op_a, op_b, op_rd, op_rd_en} !== 37'd0) begin errors++; $display("FAIL reset_operands got %h %h %h %b exp zeros", op_a, op_b, op_rd, op_rd_en); end
    reset = 1'b0;
    set_issue(1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      set_wb(1'b1, i[3:0], (i == 1) ? 16'h0011 : (i == 2) ? 16'h0022 : 16'($urandom));
      tick();
    end
    set_wb(1'b0, 4'd0, 16'h0);
    for (int i = 0; i < 16; i++) begin
      checks++; if (rf_mem[i] !== m_regs[i]) begin errors++; $display("FAIL init_reg%0d got %h exp %h", i, rf_mem[i], m_regs[i]); end
    end
  endtask

  task automatic test_basic_issue();
    set_issue(1'b1, 4'd1, 4'd2, 4'd3, 1'b1);
    tick();
    checks++; if (samp_ready !== 1'b1) begin errors++; $display("FAIL basic_ready got %b exp 1", samp_ready); end
    checks++; if (op_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", op_valid); end
    checks++; if (op_a !== 16'h0011 || op_b !== 16'h0022) begin errors++; $display("FAIL basic_ops got %h %h exp 0011 0022", op_a, op_b); end
    checks++; if (op_rd !== 4'd3 || op_rd_en !== 1'b1) begin errors++; $display("FAIL basic_rd got %0d %b exp 3 1", op_rd, op_rd_en); end
    checks++; if (busy !== 16'h0008) begin errors++; $display("FAIL basic_busy got %h exp 0008", busy); end
    checks++; if (samp_ctl !== {4'd2, 4'd1, 4'd0, 1'b0}) begin errors++; $display("FAIL basic_ctl got %h exp %h", samp_ctl, {4'd2, 4'd1, 4'd0, 1'b0}); end
  endtask

  task automatic test_raw_bypass();
    set_issue(1'b1, 4'd3, 4'd0, 4'd4, 1'b0);
    tick();
    checks++; if (samp_ready !== 1'b0) begin errors++; $display("FAIL raw_stall got %b exp 0", samp_ready); end
    checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL raw_drain got %b exp 0", op_valid); end
    set_wb(1'b1, 4'd3, 16'hBEEF);
    tick();
    set_wb(1'b0, 4'd0, 16'h0);
    checks++; if (samp_ready !== 1'b1) begin errors++; $display("FAIL raw_release got %b exp 1", samp_ready); end
    checks++; if (op_a !== 16'hBEEF) begin errors++; $display("FAIL raw_bypass got %h exp BEEF", op_a); end
    checks++; if (busy[3] !== 1'b0) begin errors++; $display("FAIL raw_busy3 got %b exp 0", busy[3]); end
    checks++; if (rf_mem[3] !== 16'hBEEF) begin errors++; $display("FAIL raw_commit got %h exp BEEF", rf_mem[3]); end
  endtask

  task automatic test_waw();
    set_issue(1'b1, 4'd0, 4'd0, 4'd5, 1'b1);
    tick();
    checks++; if (busy !== 16'h0020) begin errors++; $display("FAIL waw_first got %h exp 0020", busy); end
    tick();
    checks++; if (samp_ready !== 1'b0) begin errors++; $display("FAIL waw_stall got %b exp 0", samp_ready); end
    set_wb(1'b1, 4'd5, 16'h1234);
    tick();
    set_wb(1'b0, 4'd0, 16'h0);
    checks++; if (samp_ready !== 1'b1) begin errors++; $display("FAIL waw_release got %b exp 1", samp_ready); end
    checks++; if (busy !== 16'h0020) begin errors++; $display("FAIL waw_still_busy got %h exp 0020", busy); end
  endtask

  task automatic test_backpressure();
    logic [15:0] held;
    set_issue(1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    set_wb(1'b1, 4'd5, 16'h4321);
    tick();
    set_wb(1'b0, 4'd0, 16'h0);
    op_ready = 1'b0;
    set_issue(1'b1, 4'd6, 4'd7, 4'd8, 1'b0);
    tick();
    held = m_regs[6];
    checks++; if (op_valid !== 1'b1 || op_a !== held) begin errors++; $display("FAIL bp_load got %b %h exp 1 %h", op_valid, op_a, held); end
    set_issue(1'b1, 4'd9, 4'd10, 4'd11, 1'b0);
    tick();
    checks++; if (samp_ready !== 1'b0) begin errors++; $display("FAIL bp_stall got %b exp 0", samp_ready); end
    checks++; if (op_a !== held || op_b !== m_regs[7]) begin errors++; $display("FAIL bp_hold got %h %h exp %h %h", op_a, op_b, held, m_regs[7]); end
    op_ready = 1'b1;
    tick();
    checks++; if (samp_ready !== 1'b1) begin errors++; $display("FAIL bp_b2b_ready got %b exp 1", samp_ready); end
    checks++; if (op_valid !== 1'b1 || op_a !== m_regs[9] || op_b !== m_regs[10]) begin errors++; $display("FAIL bp_b2b_data got %b %h %h exp 1 %h %h", op_valid, op_a, op_b, m_regs[9], m_regs[10]); end
  endtask

  task automatic test_back_to_back();
    int start;
    start = n_acc;
    op_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_issue(1'b1, 4'($urandom), 4'($urandom), 4'($urandom), 1'b0);
      tick();
      checks++; if (samp_ready !== 1'b1) begin errors++; $display("FAIL stream_ready%0d got %b exp 1", i, samp_ready); end
      checks++; if (op_valid !== 1'b1 || op_a !== m_a || op_b !== m_b || op_rd !== m_rd) begin errors++; $display("FAIL stream_data%0d got %h %h %0d exp %h %h %0d", i, op_a, op_b, op_rd, m_a, m_b, m_rd); end
    end
    checks++; if (n_acc - start !== 8) begin errors++; $display("FAIL stream_count got %0d exp 8", n_acc - start); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset    = ($urandom_range(0, 49) == 0);
      op_ready = ($urandom_range(0, 3) != 0);
      set_issue($urandom_range(0, 1), 4'($urandom), 4'($urandom), 4'($urandom), $urandom_range(0, 1));
      set_wb($urandom_range(0, 2) == 0, 4'($urandom), 16'($urandom));
      tick();
      checks++;
      if (samp_ready !== exp_ready || samp_ctl !== exp_ctl || op_valid !== m_vld ||
          op_a !== m_a || op_b !== m_b || op_rd !== m_rd || op_rd_en !== m_rden || busy !== m_busy()) begin
        errors++;
        $display("FAIL rand%0d got rdy=%b ctl=%h v=%b a=%h b=%h rd=%0d en=%b busy=%h exp rdy=%b ctl=%h v=%b a=%h b=%h rd=%0d en=%b busy=%h",
                 i, samp_ready, samp_ctl, op_valid, op_a, op_b, op_rd, op_rd_en, busy,
                 exp_ready, exp_ctl, m_vld, m_a, m_b, m_rd, m_rden, m_busy());
      end
    end
    reset = 1'b0;
    set_wb(1'b0, 4'd0, 16'h0);
    for (int i = 0; i < 16; i++) begin
      checks++; if (rf_mem[i] !== m_regs[i]) begin errors++; $display("FAIL rand_reg%0d got %h exp %h", i, rf_mem[i], m_regs[i]); end
    end
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    set_issue(1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    tick();
    reset = 1'b0; op_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      set_issue(1'b1, i[3:0], i[3:0], i[3:0], 1'b1);
      tick();
    end
    checks++; if (busy !== 16'hFFFF || op_valid !== 1'b1) begin errors++; $display("FAIL mid_setup got %h %b exp FFFF 1", busy, op_valid); end
    reset = 1'b1;
    set_wb(1'b1, 4'd0, ~m_regs[0]);
    tick();
    checks++; if (samp_ctl[0] !== 1'b0 || samp_ready !== 1'b0) begin errors++; $display("FAIL mid_ctl got we=%b rdy=%b exp 0 0", samp_ctl[0], samp_ready); end
    checks++; if (op_valid !== 1'b0 || busy !== 16'h0000) begin errors++; $display("FAIL mid_clear got %b %h exp 0 0000", op_valid, busy); end
    checks++; if (rf_mem[0] !== m_regs[0]) begin errors++; $display("FAIL mid_nowrite got %h exp %h", rf_mem[0], m_regs[0]); end
    reset = 1'b0;
    set_wb(1'b0, 4'd0, 16'h0);
  endtask

  initial begin
    reset = 1'b1; op_ready = 1'b1; n_acc = 0;
    set_issue(1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    set_wb(1'b0, 4'd0, 16'h0);
    for (int i = 0; i < 16; i++) begin m_regs[i] = 16'h0; m_pend[i] = 1'b0; end
    m_vld = 0; m_a = 0; m_b = 0; m_rd = 0; m_rden = 0;
    test_reset();
    test_basic_issue();
    test_raw_bypass();
    test_waw();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
